// File: rtl/sigma_pkg.sv
// Shared SigmaCore execute-stage types: ALU opcodes, width constants and the flag bundle.
package sigma_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned SHAMT_W = $clog2(XLEN);
    localparam int unsigned OP_W    = 4;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    typedef struct packed {
        logic z;
        logic n;
        logic v;
        logic c;
    } alu_flags_t;

endpackage

// File: rtl/alu_if.sv
// Operand/opcode request and registered result/flag response between issue logic and the ALU.
interface alu_if;

    logic                             in_valid;
    logic [sigma_pkg::XLEN-1:0]       operand1;
    logic [sigma_pkg::XLEN-1:0]       operand2;
    logic [sigma_pkg::OP_W-1:0]       alu_op;
    logic                             out_valid;
    logic [sigma_pkg::XLEN-1:0]       result;
    logic                             zero_flag;
    logic                             negative_flag;
    logic                             overflow_flag;
    logic                             carry_flag;

    modport master (
        output in_valid, operand1, operand2, alu_op,
        input  out_valid, result, zero_flag, negative_flag, overflow_flag, carry_flag
    );

    modport slave (
        input  in_valid, operand1, operand2, alu_op,
        output out_valid, result, zero_flag, negative_flag, overflow_flag, carry_flag
    );

endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: result and Z/N/V/C flags for one operation.
module alu_core
    import sigma_pkg::*;
(
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic [OP_W-1:0] alu_op,
    output logic [XLEN-1:0] result_c,
    output alu_flags_t      flags_c
);

    localparam int unsigned SUM_W = XLEN + 1;

    logic [SUM_W-1:0]   sum_c;
    logic [SUM_W-1:0]   diff_c;
    logic [SHAMT_W-1:0] shamt_c;
    logic               sign1_c;
    logic               sign2_c;

    always_comb begin
        sum_c    = {1'b0, operand1} + {1'b0, operand2};
        // Subtract as op1 + ~op2 + 1 so the carry out is the no-borrow indication.
        diff_c   = {1'b0, operand1} + {1'b0, ~operand2} + SUM_W'(1);
        shamt_c  = operand2[SHAMT_W-1:0];
        sign1_c  = operand1[XLEN-1];
        sign2_c  = operand2[XLEN-1];
        result_c = '0;
        flags_c  = '0;

        case (alu_op)
            ALU_ADD: begin
                result_c  = sum_c[XLEN-1:0];
                flags_c.c = sum_c[XLEN];
                flags_c.v = (sign1_c == sign2_c) && (sum_c[XLEN-1] != sign1_c);
            end
            ALU_SUB: begin
                result_c  = diff_c[XLEN-1:0];
                flags_c.c = diff_c[XLEN];
                flags_c.v = (sign1_c != sign2_c) && (diff_c[XLEN-1] != sign1_c);
            end
            ALU_AND:  result_c = operand1 & operand2;
            ALU_OR:   result_c = operand1 | operand2;
            ALU_XOR:  result_c = operand1 ^ operand2;
            ALU_SLL:  result_c = operand1 << shamt_c;
            ALU_SRL:  result_c = operand1 >> shamt_c;
            ALU_SRA:  result_c = XLEN'($signed(operand1) >>> shamt_c);
            ALU_SLT:  result_c = XLEN'($signed(operand1) < $signed(operand2));
            ALU_SLTU: result_c = XLEN'(operand1 < operand2);
            default:  result_c = '0;
        endcase

        flags_c.z = (result_c == '0);
        flags_c.n = result_c[XLEN-1];
    end

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: one-cycle registered result/flag bank around alu_core, valid travels alongside.
module alu
    import sigma_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);

    logic [XLEN-1:0] core_result_c;
    alu_flags_t      core_flags_c;

    logic            valid_q,  valid_d;
    logic [XLEN-1:0] result_q, result_d;
    alu_flags_t      flags_q,  flags_d;

    alu_core u_core (
        .operand1 (bus.operand1),
        .operand2 (bus.operand2),
        .alu_op   (bus.alu_op),
        .result_c (core_result_c),
        .flags_c  (core_flags_c)
    );

    // Result and flags only update on a valid request; otherwise they hold.
    always_comb begin
        valid_d  = bus.in_valid;
        result_d = result_q;
        flags_d  = flags_q;
        if (bus.in_valid) begin
            result_d = core_result_c;
            flags_d  = core_flags_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign bus.out_valid     = valid_q;
    assign bus.result        = result_q;
    assign bus.zero_flag     = flags_q.z;
    assign bus.negative_flag = flags_q.n;
    assign bus.overflow_flag = flags_q.v;
    assign bus.carry_flag    = flags_q.c;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset/hold sequences, random ops vs. a reference model.
module tb_alu;
    import sigma_pkg::*;

    logic clk;
    logic rst;
    alu_if bus ();

    alu u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;   // {Z,N,V,C}
    } vec_t;

    int         n_total;
    int         n_pass;
    logic       exp_valid;
    logic [31:0] exp_res;
    logic [3:0]  exp_flg;

    function automatic logic [3:0] dut_flags();
        return {bus.zero_flag, bus.negative_flag, bus.overflow_flag, bus.carry_flag};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_outputs(input string name);
        check({name, ".valid"},  32'(bus.out_valid), 32'(exp_valid));
        check({name, ".result"}, bus.result, exp_res);
        check({name, ".flags"},  32'(dut_flags()), 32'(exp_flg));
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = v;
        bus.alu_op   = op;
        bus.operand1 = a;
        bus.operand2 = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model from the arithmetic definitions: returns {Z,N,V,C, result}.
    function automatic logic [35:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua = {32'b0, a};
        longint unsigned ub = {32'b0, b};
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned wide;
        longint          ssum;
        int              sh = int'(b % 32);
        logic [31:0]     r = '0;
        logic            v = 1'b0;
        logic            c = 1'b0;
        case (op)
            4'd0: begin
                wide = ua + ub;
                r    = wide[31:0];
                c    = wide[32];
                ssum = sa + sb;
                v    = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
            end
            4'd1: begin
                r    = a - b;
                c    = (a >= b);
                ssum = sa - sb;
                v    = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << sh;
            4'd6: r = a >> sh;
            4'd7: begin
                r = a >> sh;
                if (a[31] && sh > 0) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            4'd8: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd9: r = (ua < ub) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        return {(r == 32'd0), r[31], v, c, r};
    endfunction

    vec_t vecs[$];

    initial begin
        logic [35:0] m;
        logic [31:0] pick [8];
        n_total = 0;
        n_pass  = 0;

        vecs = '{
            '{4'h0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 4'b0000},
            '{4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1001},
            '{4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0110},
            '{4'h0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'b1011},
            '{4'h1, 32'h0000_0005, 32'h0000_0002, 32'h0000_0003, 4'b0001},
            '{4'h1, 32'h0000_0002, 32'h0000_0005, 32'hFFFF_FFFD, 4'b0100},
            '{4'h1, 32'h7000_0000, 32'h9000_0000, 32'hE000_0000, 4'b0110},
            '{4'h1, 32'h9000_0000, 32'h7000_0000, 32'h2000_0000, 4'b0011},
            '{4'h1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b1001},
            '{4'h2, 32'h0000_000F, 32'h0000_000A, 32'h0000_000A, 4'b0000},
            '{4'h3, 32'h0000_000F, 32'h0000_000A, 32'h0000_000F, 4'b0000},
            '{4'h4, 32'h0000_000F, 32'h0000_000A, 32'h0000_0005, 4'b0000},
            '{4'h8, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0000},
            '{4'h9, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1000},
            '{4'h5, 32'h0000_000F, 32'h0000_0002, 32'h0000_003C, 4'b0000},
            '{4'h6, 32'h0000_000F, 32'h0000_0002, 32'h0000_0003, 4'b0000},
            '{4'h7, 32'h0000_00F0, 32'h0000_0002, 32'h0000_003C, 4'b0000},
            '{4'h7, 32'hFFFF_FFF0, 32'h0000_0002, 32'hFFFF_FFFC, 4'b0100},
            '{4'h5, 32'hABCD_EF12, 32'h0000_0000, 32'hABCD_EF12, 4'b0100},
            '{4'h5, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 4'b0100},
            '{4'h5, 32'h0000_0001, 32'h0000_0022, 32'h0000_0004, 4'b0000},
            '{4'hF, 32'h0000_0010, 32'h0000_0005, 32'h0000_0000, 4'b1000}
        };

        // Power-on reset
        drive(1'b0, 4'h0, '0, '0);
        rst = 1'b1;
        exp_valid = 1'b0; exp_res = '0; exp_flg = '0;
        step(); step();
        check_outputs("reset_init");
        rst = 1'b0;

        // Directed vectors, back-to-back
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            step();
            exp_valid = 1'b1; exp_res = vecs[i].res; exp_flg = vecs[i].flg;
            check_outputs($sformatf("vec%0d", i));
        end

        // Idle cycle: result/flags hold, valid drops
        drive(1'b1, 4'h1, 32'h0000_0002, 32'h0000_0005);
        step();
        drive(1'b0, 4'h0, 32'h1234_5678, 32'h1111_1111);
        step();
        exp_valid = 1'b0; exp_res = 32'hFFFF_FFFD; exp_flg = 4'b0100;
        check_outputs("hold_idle");

        // Asynchronous reset mid-stream with a valid op in flight
        drive(1'b1, 4'h0, 32'h7FFF_FFFF, 32'h0000_0001);
        step();
        drive(1'b1, 4'h4, 32'hFFFF_0000, 32'h0F0F_0F0F);
        #2 rst = 1'b1;
        #1;
        exp_valid = 1'b0; exp_res = '0; exp_flg = '0;
        check_outputs("reset_async");
        step();
        check_outputs("reset_held");
        rst = 1'b0;
        drive(1'b1, 4'h0, 32'h0000_0001, 32'h0000_0002);
        step();
        exp_valid = 1'b1; exp_res = 32'h0000_0003; exp_flg = 4'b0000;
        check_outputs("post_reset_add");

        // Random traffic against the reference model, including idle cycles
        pick = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_001F, 32'h0000_0020, 32'h0};
        for (int k = 0; k < 300; k++) begin
            logic        v;
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            v  = ($urandom_range(0, 4) != 0);
            op = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 6)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 6)] : $urandom;
            drive(v, op, a, b);
            step();
            exp_valid = v;
            if (v) begin
                m = ref_alu(op, a, b);
                exp_res = m[31:0];
                exp_flg = m[35:32];
            end
            check_outputs($sformatf("rand%0d_op%0h", k, op));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit integer ALU for the SigmaCore RISC-V execute stage.
- Computes one of ten operations on two operands and produces result plus Z/N/V/C status flags.
- The result/flag bank is registered: one clock of latency, with a valid bit that travels alongside.
- Opcodes come from the shared sigma_pkg package.

Parameters:
- XLEN, 32, operand/result width; shift amount uses the low $clog2(XLEN) bits of operand2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands/op valid this cycle
- operand1  input  XLEN  first source (rs1)
- operand2  input  XLEN  second source (rs2/imm; shift amount in low 5 bits)
- alu_op  input  4  operation select (alu_op_e from sigma_pkg)
- out_valid  output  1  registered in_valid
- result  output  XLEN  registered result
- zero_flag  output  1  result == 0
- negative_flag  output  1  result[XLEN-1]
- overflow_flag  output  1  signed overflow (ADD/SUB only)
- carry_flag  output  1  carry out (ADD) / no-borrow (SUB)

Behaviour:
- Reset (async, rst=1): out_valid, result, and all four flags go to 0 immediately; they hold there while rst=1.
- Latency:
  - On each rising clk edge with rst=0, the inputs are sampled.
  - result and flags load from the combinational compute when in_valid=1.
  - When in_valid=0, result and flags hold their previous values; out_valid <= 0.
  - out_valid <= in_valid.
- Operations (opcode encoding):
  - ADD 0000: op1+op2, modulo 2^XLEN
  - SUB 0001: op1-op2
  - AND 0010, OR 0011, XOR 0100: bitwise
  - SLL 0101: op1 << op2[4:0]
  - SRL 0110: logical right shift by op2[4:0]
  - SRA 0111: arithmetic right shift by op2[4:0], sign-filled
  - SLT 1000: 1 if signed op1 < op2, else 0
  - SLTU 1001: 1 if unsigned op1 < op2, else 0
- Shift amount: only op2[4:0] is used; upper bits are ignored (shift by 34 = shift by 2). Shift by 0 passes op1 through.
- Undefined opcodes (1010–1111): result = 0; flags computed from that result (Z=1, N=0, V=0, C=0). No X is ever driven.
- zero_flag and negative_flag are derived from the final result for every op.
- overflow_flag:
  - ADD: op1 and op2 have the same sign and the result sign differs.
  - SUB: op1 and op2 have different signs and the result sign differs from op1.
  - All other ops: 0.
- carry_flag:
  - ADD: bit XLEN of the (XLEN+1)-bit sum.
  - SUB: 1 when unsigned op1 >= op2 (no borrow); implement as op1 + ~op2 + 1 carry out.
  - All other ops: 0.
- Reset mid-operation: any in-flight result is discarded; the first valid output after reset release appears one edge after the first sampled in_valid.
- Back-to-back: a new operation is accepted every cycle; no stall or backpressure.

Decomposition:
- sigma_pkg holds:
  - typedef enum logic [3:0] alu_op_e with ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU at the encodings above;
  - XLEN default constant.
- One natural sub-module: alu_core, the purely combinational result/flag compute.
- alu wraps alu_core with the registers and the async reset.

Test Plan:
- Reset: assert rst mid-stream -> all outputs 0 immediately; after release, ADD 1+2 with in_valid -> next edge result=00000003, flags 0000, out_valid=1.
- Arithmetic flags:
  - ADD FFFFFFFF+00000001 -> 00000000, Z=1 C=1 V=0.
  - ADD 7FFFFFFF+1 -> 80000000, N=1 V=1 C=0.
  - ADD 80000000+80000000 -> 00000000, Z=1 V=1 C=1.
- SUB:
  - 5-2 -> 00000003, C=1.
  - 2-5 -> FFFFFFFD, N=1 C=0.
  - 70000000-90000000 -> E0000000, N=1 V=1 C=0.
  - 90000000-70000000 -> 20000000, V=1 C=1.
- Logic/compare:
  - F&A=0000000A; F|A=0000000F; F^A=00000005.
  - SLT FFFFFFFF,1 -> 1; SLTU FFFFFFFF,1 -> 0.
- Shifts:
  - SLL F<<2=3C; SRL F>>2=3; SRA 000000F0>>2=0000003C.
  - SRA FFFFFFF0>>2=FFFFFFFC (N=1).
  - SLL ABCDEF12<<0 unchanged (N=1); SLL 1<<31=80000000.
  - SLL 1 by 34 -> 00000004.
- Undefined op 1111 with 10,5 -> result 0, Z=1, others 0. in_valid=0 cycle -> result holds, out_valid=0.
